// File: rtl/ib_cnu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ib_cnu_pkg
// Purpose  : Shared types, derived-constant helpers and the fold/unfold
//            symmetry functions for the IB check-node final LUT stage.
// Revision : 1.0 - initial release
// ============================================================================
package ib_cnu_pkg;

    // Widest message the fold/unfold helpers can handle.
    localparam int MAX_Q = 16;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } load_state_t;

    // Index width for n items; never below one bit.
    function automatic int calc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LUT entries held in one frame.
    function automatic int calc_entries(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    // Write beats needed to fill one frame.
    function automatic int calc_beats(input int addr_bits, input int banks);
        return (1 << addr_bits) / banks;
    endfunction

    // Map a q-bit message onto its magnitude index using the MSB as symmetry bit.
    function automatic logic [MAX_Q-1:0] fold(input logic [MAX_Q-1:0] x, input int q);
        logic [MAX_Q-1:0] top;
        logic [MAX_Q-1:0] mask;
        top  = MAX_Q'(1) << (q - 1);
        mask = top - MAX_Q'(1);
        return ((x & top) != '0) ? (x & mask) : (~x & mask);
    endfunction

    // Rebuild a q-bit message from a stored magnitude and a sign.
    function automatic logic [MAX_Q-1:0] unfold(input logic [MAX_Q-1:0] mag, input logic sgn,
                                               input int q);
        logic [MAX_Q-1:0] top;
        logic [MAX_Q-1:0] mask;
        top  = MAX_Q'(1) << (q - 1);
        mask = top - MAX_Q'(1);
        return sgn ? (top | (mag & mask)) : (~mag & mask);
    endfunction

endpackage : ib_cnu_pkg
`default_nettype wire

// File: rtl/ib_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : ib_lut_loader
// Purpose  : Refills one LUT frame from a bank-interleaved write stream:
//            IDLE -> LOAD (one beat per accepted handshake) -> COMMIT.
//            Owns the per-frame valid flags and the entry write strobes.
// Revision : 1.0 - initial release
// ============================================================================
module ib_lut_loader
    import ib_cnu_pkg::*;
#(
    parameter int MULTI_FRAME_NUM = 2,
    parameter int BEAT_NUM        = 8,
    localparam int FW             = calc_width(MULTI_FRAME_NUM),
    localparam int BW             = calc_width(BEAT_NUM)
)(
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       load_start,
    input  logic [FW-1:0]              load_frame,
    input  logic                       lut_wr_valid,
    output logic                       lut_wr_ready,
    output logic                       load_busy,
    output logic                       wr_en,
    output logic [FW-1:0]              wr_frame,
    output logic [BW-1:0]              wr_beat,
    output logic [MULTI_FRAME_NUM-1:0] frame_valid
);

    load_state_t                r_state;
    load_state_t                w_state_nxt;
    logic [FW-1:0]              r_frame;
    logic [BW-1:0]              r_beat;
    logic [MULTI_FRAME_NUM-1:0] r_frame_valid;
    logic                       w_last_beat;

    assign w_last_beat = (r_beat == BW'(BEAT_NUM - 1));
    assign wr_frame    = r_frame;
    assign wr_beat     = r_beat;
    assign frame_valid = r_frame_valid;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode and handshake/strobe outputs.
    always_comb begin
        w_state_nxt  = r_state;
        lut_wr_ready = 1'b0;
        load_busy    = 1'b0;
        wr_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_start) w_state_nxt = LOAD;
            end
            LOAD: begin
                lut_wr_ready = 1'b1;
                load_busy    = 1'b1;
                wr_en        = lut_wr_valid;
                if (lut_wr_valid && w_last_beat) w_state_nxt = COMMIT;
            end
            COMMIT: begin
                load_busy   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Target frame latch, beat counter and frame valid flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame       <= '0;
            r_beat        <= '0;
            r_frame_valid <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_start) begin
                        r_frame                   <= load_frame;
                        r_beat                    <= '0;
                        r_frame_valid[load_frame] <= 1'b0;
                    end
                end
                LOAD: begin
                    if (lut_wr_valid) r_beat <= r_beat + 1'b1;
                end
                COMMIT: r_frame_valid[r_frame] <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule : ib_lut_loader
`default_nettype wire

// File: rtl/ib_cnu_fn_lut_stage.sv
`default_nettype none
// ============================================================================
// Module   : ib_cnu_fn_lut_stage
// Purpose  : Final IB check-node stage. Each edge folds (t, m) into a LUT
//            address, reads a magnitude from a multi-frame flop LUT and
//            unfolds it with the product sign into a c2v message. Two-stage
//            pipeline; an on-block loader refills idle frames.
// Options  : IB_CNU_V2C_PROBE_EN adds out_v2c_probe (in_m aligned to out_c2v).
// Revision : 1.0 - initial release
// ============================================================================
module ib_cnu_fn_lut_stage
    import ib_cnu_pkg::*;
#(
    parameter int QUAN_SIZE       = 3,
    parameter int CN_DEGREE       = 6,
    parameter int CNU_NUM         = 2,
    parameter int ENTRY_ADDR      = 4,
    parameter int LUT_PORT_SIZE   = 2,
    parameter int BANK_NUM        = 2,
    parameter int MULTI_FRAME_NUM = 2,
    localparam int FW             = calc_width(MULTI_FRAME_NUM),
    localparam int DW             = CNU_NUM * CN_DEGREE * QUAN_SIZE
)(
    input  logic                        read_clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    input  logic [FW-1:0]               in_frame,
    input  logic [DW-1:0]               in_t,
    input  logic [DW-1:0]               in_m,
    output logic                        out_valid,
    output logic [FW-1:0]               out_frame,
    output logic [DW-1:0]               out_c2v,
    output logic                        lut_miss,
    input  logic                        load_start,
    input  logic [FW-1:0]               load_frame,
    input  logic                        lut_wr_valid,
    output logic                        lut_wr_ready,
    input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_wr_data,
    output logic                        load_busy,
    output logic [MULTI_FRAME_NUM-1:0]  frame_valid
`ifdef IB_CNU_V2C_PROBE_EN
    ,
    output logic [DW-1:0]               out_v2c_probe
`endif
);

    localparam int ENTRY_NUM = calc_entries(ENTRY_ADDR);
    localparam int BEAT_NUM  = calc_beats(ENTRY_ADDR, BANK_NUM);
    localparam int BW        = calc_width(BEAT_NUM);
    localparam int EDGE_NUM  = CNU_NUM * CN_DEGREE;

    logic                     w_wr_en;
    logic [FW-1:0]            w_wr_frame;
    logic [BW-1:0]            w_wr_beat;
    logic [LUT_PORT_SIZE-1:0] w_bank_data [BANK_NUM];
    logic [LUT_PORT_SIZE-1:0] w_lut [MULTI_FRAME_NUM][ENTRY_NUM];

    logic [EDGE_NUM*ENTRY_ADDR-1:0] w_addr;
    logic [EDGE_NUM*ENTRY_ADDR-1:0] r_s1_addr;
    logic [EDGE_NUM-1:0]            w_sign;
    logic [EDGE_NUM-1:0]            r_s1_sign;
    logic [FW-1:0]                  r_s1_frame;
    logic                           r_s1_valid;
    logic [DW-1:0]                  w_c2v;

    ib_lut_loader #(
        .MULTI_FRAME_NUM (MULTI_FRAME_NUM),
        .BEAT_NUM        (BEAT_NUM)
    ) u_loader (
        .clk          (read_clk),
        .rstn         (rstn),
        .load_start   (load_start),
        .load_frame   (load_frame),
        .lut_wr_valid (lut_wr_valid),
        .lut_wr_ready (lut_wr_ready),
        .load_busy    (load_busy),
        .wr_en        (w_wr_en),
        .wr_frame     (w_wr_frame),
        .wr_beat      (w_wr_beat),
        .frame_valid  (frame_valid)
    );

    // Bank 0 sits in the upper bits of the write word.
    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        assign w_bank_data[b] = lut_wr_data[(BANK_NUM-1-b)*LUT_PORT_SIZE +: LUT_PORT_SIZE];
    end

    for (genvar f = 0; f < MULTI_FRAME_NUM; f++) begin : g_frame
        for (genvar e = 0; e < ENTRY_NUM; e++) begin : g_entry
            logic [LUT_PORT_SIZE-1:0] r_entry;
            // Entry e is filled by bank e%BANK_NUM on beat e/BANK_NUM.
            always_ff @(posedge read_clk or negedge rstn) begin
                if (!rstn) begin
                    r_entry <= '0;
                end else if (w_wr_en && (w_wr_frame == FW'(f)) &&
                             (w_wr_beat == BW'(e / BANK_NUM))) begin
                    r_entry <= w_bank_data[e % BANK_NUM];
                end
            end
            assign w_lut[f][e] = r_entry;
        end
    end

    for (genvar e = 0; e < EDGE_NUM; e++) begin : g_edge
        logic [QUAN_SIZE-1:0]     w_t;
        logic [QUAN_SIZE-1:0]     w_m;
        logic [LUT_PORT_SIZE-1:0] w_ft;
        logic [LUT_PORT_SIZE-1:0] w_fm;
        logic [LUT_PORT_SIZE-1:0] w_mag;

        assign w_t  = in_t[e*QUAN_SIZE +: QUAN_SIZE];
        assign w_m  = in_m[e*QUAN_SIZE +: QUAN_SIZE];
        assign w_ft = LUT_PORT_SIZE'(fold(MAX_Q'(w_t), QUAN_SIZE));
        assign w_fm = LUT_PORT_SIZE'(fold(MAX_Q'(w_m), QUAN_SIZE));
        assign w_addr[e*ENTRY_ADDR +: ENTRY_ADDR] = {w_ft, w_fm};
        assign w_sign[e] = w_t[QUAN_SIZE-1] ~^ w_m[QUAN_SIZE-1];

        // Lookup happens between the two pipeline registers.
        assign w_mag = w_lut[r_s1_frame][r_s1_addr[e*ENTRY_ADDR +: ENTRY_ADDR]];
        assign w_c2v[e*QUAN_SIZE +: QUAN_SIZE] =
            QUAN_SIZE'(unfold(MAX_Q'(w_mag), r_s1_sign[e], QUAN_SIZE));
    end

    // Stage 1: capture folded addresses, signs and frame select.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_frame <= '0;
            r_s1_addr  <= '0;
            r_s1_sign  <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_frame <= in_frame;
            r_s1_addr  <= w_addr;
            r_s1_sign  <= w_sign;
        end
    end

    // Stage 2: register the unfolded c2v messages.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_frame <= '0;
            out_c2v   <= '0;
        end else begin
            out_valid <= r_s1_valid;
            out_frame <= r_s1_frame;
            out_c2v   <= w_c2v;
        end
    end

    // Sticky flag for lookups into a frame that is not (or no longer) loaded.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            lut_miss <= 1'b0;
        end else if (r_s1_valid && !frame_valid[r_s1_frame]) begin
            lut_miss <= 1'b1;
        end
    end

`ifdef IB_CNU_V2C_PROBE_EN
    logic [DW-1:0] r_probe_s1;

    // Delay v2c messages to line up with out_c2v.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            r_probe_s1    <= '0;
            out_v2c_probe <= '0;
        end else begin
            r_probe_s1    <= in_m;
            out_v2c_probe <= r_probe_s1;
        end
    end
`endif

endmodule : ib_cnu_fn_lut_stage
`default_nettype wire

// File: tb/tb_ib_cnu_fn_lut_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ib_cnu_fn_lut_stage
// Purpose  : Directed self-checking bench for ib_cnu_fn_lut_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ib_cnu_fn_lut_stage;

    localparam int Q     = 3;
    localparam int MF    = 2;
    localparam int FW    = 1;
    localparam int EDGES = 12;
    localparam int DW    = EDGES * Q;

    logic          read_clk = 1'b0;
    logic          rstn = 1'b1;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_frame = '0;
    logic [DW-1:0] in_t = '0;
    logic [DW-1:0] in_m = '0;
    logic          out_valid;
    logic [FW-1:0] out_frame;
    logic [DW-1:0] out_c2v;
    logic          lut_miss;
    logic          load_start = 1'b0;
    logic [FW-1:0] load_frame = '0;
    logic          lut_wr_valid = 1'b0;
    logic          lut_wr_ready;
    logic [3:0]    lut_wr_data = '0;
    logic          load_busy;
    logic [MF-1:0] frame_valid;
`ifdef IB_CNU_V2C_PROBE_EN
    logic [DW-1:0] out_v2c_probe;
`endif

    int         n_checks = 0;
    int         n_fail = 0;
    int         acc_cnt = 0;
    int         commit_cnt = 0;
    int         a0, c0;
    logic [1:0] lut_m [MF][16];

    ib_cnu_fn_lut_stage #(
        .QUAN_SIZE(3), .CN_DEGREE(6), .CNU_NUM(2), .ENTRY_ADDR(4),
        .LUT_PORT_SIZE(2), .BANK_NUM(2), .MULTI_FRAME_NUM(2)
    ) dut (
        .read_clk     (read_clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_frame     (in_frame),
        .in_t         (in_t),
        .in_m         (in_m),
        .out_valid    (out_valid),
        .out_frame    (out_frame),
        .out_c2v      (out_c2v),
        .lut_miss     (lut_miss),
        .load_start   (load_start),
        .load_frame   (load_frame),
        .lut_wr_valid (lut_wr_valid),
        .lut_wr_ready (lut_wr_ready),
        .lut_wr_data  (lut_wr_data),
        .load_busy    (load_busy),
        .frame_valid  (frame_valid)
`ifdef IB_CNU_V2C_PROBE_EN
        ,
        .out_v2c_probe(out_v2c_probe)
`endif
    );

    always #5 read_clk = ~read_clk;

    // Count accepted write beats and COMMIT cycles mid-cycle.
    always @(negedge read_clk) begin
        if (rstn && lut_wr_valid && lut_wr_ready) acc_cnt <= acc_cnt + 1;
        if (rstn && load_busy && !lut_wr_ready) commit_cnt <= commit_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge read_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fold_m(input logic [2:0] x);
        return x[2] ? x[1:0] : ~x[1:0];
    endfunction

    function automatic logic [2:0] c2v_model(input int fr, input logic [2:0] t, input logic [2:0] m);
        logic [3:0] a;
        logic [1:0] mag;
        logic       s;
        a   = {fold_m(t), fold_m(m)};
        mag = lut_m[fr][a];
        s   = t[2] ~^ m[2];
        return s ? {1'b1, mag} : {1'b0, ~mag};
    endfunction

    function automatic logic [3:0] beat_data(input int mode, input int k);
        logic [2:0] kk;
        kk = k[2:0];
        case (mode)
            0:       return 4'hF;
            1:       return {kk[1:0], ~kk[1:0]};
            default: return {kk[1:0] ^ 2'b10, kk[0], kk[2]};
        endcase
    endfunction

    task automatic do_load(input int fr, input int mode, input bit throttle, input int poke_at);
        int         beats;
        int         cyc;
        logic [3:0] d;
        load_frame = fr[FW-1:0];
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("ready_on_load", lut_wr_ready, 1);
        beats = 0;
        cyc   = 0;
        while (beats < 8 && cyc < 64) begin
            lut_wr_data  = beat_data(mode, beats);
            lut_wr_valid = throttle ? ((cyc % 2) == 0) : 1'b1;
            if (beats == poke_at) begin
                load_start = 1'b1;
                load_frame = ~fr[FW-1:0];
            end else begin
                load_start = 1'b0;
            end
            if (lut_wr_valid && lut_wr_ready) beats++;
            step();
            cyc++;
        end
        lut_wr_valid = 1'b0;
        load_start   = 1'b0;
        check("load_beats", beats, 8);
        if (!throttle) check("load_cycles", cyc, 8);
        check("commit_state", {load_busy, lut_wr_ready}, 2'b10);
        check("fv_before_commit", frame_valid[fr], 0);
        step();
        check("fv_after_commit", frame_valid[fr], 1);
        check("idle_after_commit", load_busy, 0);
        for (int k = 0; k < 8; k++) begin
            d = beat_data(mode, k);
            lut_m[fr][2*k]   = d[3:2];
            lut_m[fr][2*k+1] = d[1:0];
        end
    endtask

    // Stream n vectors back-to-back (fr < 0 alternates frames) and score outputs.
    task automatic run_burst(input int n, input int fr, input int seed);
        logic [DW-1:0] exp_c2v [32];
        logic [DW-1:0] sent_m [32];
        int            exp_fr [32];
        logic [2:0]    t, m;
        int            f;
        for (int j = 0; j <= n + 1; j++) begin
            if (j < n) begin
                f = (fr < 0) ? (j % 2) : fr;
                for (int e = 0; e < EDGES; e++) begin
                    t = 3'((e*5 + j*3 + seed) & 7);
                    m = 3'((e*3 + j + seed*7 + 2) & 7);
                    in_t[e*Q +: Q] = t;
                    in_m[e*Q +: Q] = m;
                    exp_c2v[j][e*Q +: Q] = c2v_model(f, t, m);
                end
                in_frame  = f[FW-1:0];
                in_valid  = 1'b1;
                sent_m[j] = in_m;
                exp_fr[j] = f;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (j >= 1 && j <= n) begin
                check("burst_valid", out_valid, 1);
                check("burst_frame", out_frame, exp_fr[j-1]);
                check("burst_c2v", out_c2v, exp_c2v[j-1]);
`ifdef IB_CNU_V2C_PROBE_EN
                check("probe", out_v2c_probe, sent_m[j-1]);
`endif
            end else if (j == n + 1) begin
                check("burst_idle", out_valid, 0);
            end
        end
    endtask

    task automatic send_one(input string tag, input logic [2:0] t, input logic [2:0] m,
                            input int fr, input logic [2:0] exp);
        in_t     = {EDGES{t}};
        in_m     = {EDGES{m}};
        in_frame = fr[FW-1:0];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("latency_not_early", out_valid, 0);
        step();
        check("directed_valid", out_valid, 1);
        check("directed_frame", out_frame, fr);
        check(tag, out_c2v, {EDGES{exp}});
    endtask

    initial begin
        for (int f = 0; f < MF; f++)
            for (int a = 0; a < 16; a++) lut_m[f][a] = 2'b00;

        #1 rstn = 1'b0;
        repeat (3) @(posedge read_clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_c2v", out_c2v, 0);
        check("rst_out_frame", out_frame, 0);
        check("rst_lut_miss", lut_miss, 0);
        check("rst_load_busy", load_busy, 0);
        check("rst_wr_ready", lut_wr_ready, 0);
        check("rst_frame_valid", frame_valid, 0);
        rstn = 1'b1;
        step();

        do_load(0, 0, 1'b0, -1);
        send_one("c2v_pos", 3'b101, 3'b110, 0, 3'b111);
        send_one("c2v_neg", 3'b001, 3'b110, 0, 3'b000);

        fork
            do_load(1, 1, 1'b0, -1);
            run_burst(12, 0, 1);
        join
        check("fv_both", frame_valid, 2'b11);

        send_one("f1_entry15", 3'b000, 3'b000, 1, 3'b100);
        send_one("f1_entry3", 3'b100, 3'b111, 1, 3'b110);
        run_burst(6, 1, 2);
        run_burst(8, -1, 4);
        check("no_miss", lut_miss, 0);

        a0 = acc_cnt;
        c0 = commit_cnt;
        do_load(0, 2, 1'b1, 3);
        check("throttle_beats", acc_cnt - a0, 8);
        check("throttle_commits", commit_cnt - c0, 1);
        check("fv_after_throttle", frame_valid, 2'b11);
        run_burst(6, -1, 3);

        // Reset in the middle of a frame-1 load, after three beats.
        load_frame = 1'b1;
        load_start = 1'b1;
        step();
        load_start   = 1'b0;
        lut_wr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lut_wr_data = beat_data(2, k);
            step();
        end
        lut_wr_valid = 1'b0;
        rstn = 1'b0;
        #2;
        check("midrst_frame_valid", frame_valid, 0);
        check("midrst_wr_ready", lut_wr_ready, 0);
        check("midrst_load_busy", load_busy, 0);
        check("midrst_out_valid", out_valid, 0);
        rstn = 1'b1;
        for (int f = 0; f < MF; f++)
            for (int a = 0; a < 16; a++) lut_m[f][a] = 2'b00;
        step();
        check("miss_clear_after_reset", lut_miss, 0);

        // Read frame 1 before it has been loaded.
        in_t     = {EDGES{3'b101}};
        in_m     = {EDGES{3'b110}};
        in_frame = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("miss_not_early", lut_miss, 0);
        step();
        check("miss_set", lut_miss, 1);
        check("cleared_lut_c2v", out_c2v, {EDGES{3'b100}});

        do_load(1, 1, 1'b0, -1);
        check("miss_sticky", lut_miss, 1);
        run_burst(4, 1, 5);
        check("miss_sticky_end", lut_miss, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ib_cnu_fn_lut_stage
`default_nettype wire
